vga_fetch_scheduler: RTL

- Sequences per-line pixel fetches from a single-ported video memory into a ping-pong line buffer, driven by the 640x480 pixel counters (hcount 0..1599, vcount 0..524).
- Shares the memory port with a host port; display fetch has strict priority.
- Swaps display and fill banks at end of line.
- Flags underrun when a fetch misses its horizontal-blanking deadline.

---
 rtl/vga_fetch_scheduler.sv | 101 ++++++++++
 1 files changed

// File: rtl/vga_fetch_scheduler.sv
// vga_fetch_scheduler: per-line video fetch into a ping-pong line buffer, sharing one memory port with a host
// Ports: clk/reset (sync, active-high); hcount/vcount pixel counters; mem_addr/mem_rd/mem_we shared memory drive;
// lb_we/lb_waddr/lb_bank line-buffer fill side; disp_bank bank on screen; host_req/host_we/host_addr host request,
// host_gnt same-cycle grant, host_rvalid host read return; fetch_underrun sticky deadline miss.
// Optional: define VGA_UNDERRUN_COUNT_EN to add underrun_count[15:0], a saturating count of deadline misses.
module vga_fetch_scheduler #(
  parameter int LINE_WORDS = 40,
  parameter int ADDR_W = 16,
  parameter int BASE_ADDR = 0,
  parameter int RD_LAT = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [10:0]       hcount,
  input  logic [9:0]        vcount,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  output logic              mem_we,
  output logic              lb_we,
  output logic [5:0]        lb_waddr,
  output logic              lb_bank,
  output logic              disp_bank,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  output logic              host_gnt,
  output logic              host_rvalid,
  output logic              fetch_underrun
`ifdef VGA_UNDERRUN_COUNT_EN
  ,
  output logic [15:0]       underrun_count
`endif
);
  localparam int CW = $clog2(LINE_WORDS + 1);
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;
  state_t st;
  logic [ADDR_W-1:0] ptr, nptr;
  logic [CW-1:0] icnt, rcnt;
  logic [RD_LAT-1:0] pv, pt;
  logic trig, eol, deadline, fiss, line_trig;
  assign trig = st == IDLE && hcount == 11'd1280 && (vcount <= 10'd478 || vcount == 10'd524);
  assign eol = hcount == 11'd1599;
  assign deadline = eol && (st == ISSUE || st == DRAIN);
  // Word 0 goes out in the trigger cycle itself, so the fetch holds the port for exactly LINE_WORDS cycles.
  assign fiss = trig || (st == ISSUE && !deadline);
  assign nptr = vcount == 10'd524 ? ADDR_W'(BASE_ADDR) : ptr + ADDR_W'(LINE_WORDS);
  assign host_gnt = host_req && !trig && st != ISSUE;
  assign mem_addr = fiss ? (trig ? nptr : ptr + ADDR_W'(icnt)) : host_addr;
  assign mem_rd = fiss || (host_gnt && !host_we);
  assign mem_we = host_gnt && host_we;
  assign lb_we = pv[RD_LAT-1] && pt[RD_LAT-1];
  assign host_rvalid = pv[RD_LAT-1] && !pt[RD_LAT-1];
  assign lb_waddr = 6'(rcnt);
  assign lb_bank = ~disp_bank;
  always_ff @(posedge clk) begin
    if (reset) begin
      st <= IDLE;
      ptr <= ADDR_W'(BASE_ADDR);
      icnt <= '0;
      rcnt <= '0;
      pv <= '0;
      pt <= '0;
      disp_bank <= 1'b0;
      line_trig <= 1'b0;
      fetch_underrun <= 1'b0;
    end else begin
      // pv/pt: read-in-flight valid and fetch tag; an abort drops only fetch-tagged slots
      pv[0] <= fiss || (host_gnt && !host_we);
      pt[0] <= fiss;
      for (int k = 1; k < RD_LAT; k++) begin
        pv[k] <= pv[k-1] && !(deadline && pt[k-1]);
        pt[k] <= pt[k-1];
      end
      if (lb_we) rcnt <= rcnt + 1'b1;
      if (trig) begin
        ptr <= nptr;
        icnt <= CW'(1);
        rcnt <= '0;
        line_trig <= 1'b1;
        st <= ISSUE;
      end
      if (st == ISSUE) begin
        icnt <= icnt + 1'b1;
        if (icnt == CW'(LINE_WORDS - 1)) st <= DRAIN;
      end
      if (st == DRAIN && rcnt == CW'(LINE_WORDS)) st <= DONE;
      if (eol) begin
        disp_bank <= disp_bank ^ line_trig;
        line_trig <= 1'b0;
        st <= IDLE;
        if (deadline) fetch_underrun <= 1'b1;
      end
    end
  end
`ifdef VGA_UNDERRUN_COUNT_EN
  always_ff @(posedge clk) begin
    if (reset) underrun_count <= '0;
    else if (deadline && underrun_count != 16'hFFFF) underrun_count <= underrun_count + 1'b1;
  end
`endif
endmodule
